// File: rtl/uart_reader_if.sv
// Byte-level receive handshake between the UART reader and its consumer.
// Latency: none (wires only).
// Backpressure: consumer pops with a one-cycle rx_rd pulse while rx_ready is high.
interface uart_reader_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_rd;

  modport master (output rx_ready, output rx_data, input rx_rd);
  modport slave  (input rx_ready, input rx_data, output rx_rd);
endinterface

// File: rtl/uart_reader.sv
// UART 8N1 receiver with a show-ahead byte FIFO (optional even parity: RX_PARITY_EN).
// Latency: byte visible on rx_ready about 2 + (HDIV_CNT+1) + 9*(DIV_CNT+1) + 1 clk after the start edge.
// Backpressure: none on the line; a full FIFO drops the new byte and pulses overrun.
module uart_reader #(
  parameter logic [9:0] DIV_CNT  = 10'd867,
  parameter logic [9:0] HDIV_CNT = 10'd433,
  parameter int         FIFO_AW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_reader_if.master rd_if,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overrun,
  output logic          parity_err
);

  localparam int                 DEPTH_I = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH   = {1'b1, {FIFO_AW{1'b0}}};

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state;
  logic               rx_m;
  logic               rx_s;
  logic [9:0]         div_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;
  logic               par_bad;

  logic [7:0]         mem [DEPTH_I];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW-1:0] rd_ptr_n;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_n;
  logic               stop_hit;
  logic               good_byte;
  logic               pop;
  logic               push;
  logic               drop;

`ifdef RX_PARITY_EN
  logic               par_bit;
  assign par_bad = ^{shift, par_bit};
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Push/pop decisions for the stop-bit sample cycle; a simultaneous pop frees room in a full FIFO.
  always_comb begin
    stop_hit  = (state == STOP) && (div_cnt == DIV_CNT);
    good_byte = stop_hit && rx_s && !par_bad;
    pop       = rd_if.rx_rd && (count != '0);
    push      = good_byte && ((count != DEPTH) || pop);
    drop      = good_byte && (count == DEPTH) && !pop;
    rd_ptr_n  = rd_ptr + FIFO_AW'(pop);
    count_n   = count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  end

  // Frame FSM: start mid-point check, mid-bit data sampling, stop check and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= drop;
`ifdef RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            div_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (div_cnt == HDIV_CNT) begin
            div_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high before mid-start: treat as noise.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end
        DATA: begin
          if (div_cnt == DIV_CNT) begin
            div_cnt <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end
`ifdef RX_PARITY_EN
        PARITY: begin
          if (div_cnt == DIV_CNT) begin
            div_cnt <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end
`endif
        STOP: begin
          if (div_cnt == DIV_CNT) begin
            // Return to IDLE at mid-stop so a back-to-back start edge is not missed.
            div_cnt <= '0;
            state   <= IDLE;
            rx_busy <= 1'b0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end
`ifdef RX_PARITY_EN
            else if (par_bad) begin
              parity_err <= 1'b1;
            end
`endif
          end else begin
            div_cnt <= div_cnt + 10'd1;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Show-ahead FIFO; rx_data is registered so it holds the last byte once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_I; i++) begin
        mem[i] <= '0;
      end
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      rd_if.rx_ready <= 1'b0;
      rd_if.rx_data  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      rd_ptr         <= rd_ptr_n;
      count          <= count_n;
      rd_if.rx_ready <= (count_n != '0);
      if (count_n != '0) begin
        // The new head may be the byte being written this very cycle.
        rd_if.rx_data <= (push && (wr_ptr == rd_ptr_n)) ? shift : mem[rd_ptr_n];
      end
    end
  end

endmodule

// File: tb/tb_uart_reader.sv
// Bench for uart_reader: frame-level reference model feeding an expected-byte queue,
// with a separate consumer/monitor popping and comparing whatever the DUT presents.
// Uses a short bit period (16 clk) to keep runs small.
module tb_uart_reader;

  localparam logic [9:0] DIV   = 10'd15;
  localparam logic [9:0] HDIV  = 10'd7;
  localparam int         BIT   = 16;
  localparam int         HALF  = 8;
  localparam int         DEPTH = 4;
`ifdef RX_PARITY_EN
  localparam bit         PAR_EN = 1'b1;
  localparam int         NPAY   = 9;
`else
  localparam bit         PAR_EN = 1'b0;
  localparam int         NPAY   = 8;
`endif
  // Stop sample edge counted from the first clock edge that sees the start bit.
  localparam int         STOP_AT = 2 + HALF + (NPAY + 1) * BIT;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic rx_busy;
  logic frame_err;
  logic overrun;
  logic parity_err;
  logic rd_mon;
  logic rd_tst;

  uart_reader_if ifc ();
  assign ifc.rx_rd = rd_mon | rd_tst;

  uart_reader #(.DIV_CNT(DIV), .HDIV_CNT(HDIV), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_if      (ifc),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         fe_cnt = 0, ovr_cnt = 0, pe_cnt = 0;
  int         exp_fe = 0, exp_ovr = 0, exp_pe = 0;
  logic [7:0] exp_q [$];
  bit         consume_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Reference model: outcome of one frame from its line-level contents.
  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok) exp_fe++;
    else if (PAR_EN && !par_ok) exp_pe++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovr++;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int gap);
    rx = 1'b0;
    wait_cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(BIT);
    end
    if (PAR_EN) begin
      rx = (^d) ^ ~par_ok;
      wait_cycles(BIT);
    end
    rx = stop_ok;
    model_frame(d, stop_ok, par_ok);
    wait_cycles(BIT);
    rx = 1'b1;
    wait_cycles(gap);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || ifc.rx_ready) && n < 400) begin
      wait_cycles(1);
      n++;
    end
    check("drain_in_time", {31'd0, n < 400}, 32'd1);
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_frame_err_cnt"}, fe_cnt, exp_fe);
    check({tag, "_overrun_cnt"}, ovr_cnt, exp_ovr);
    check({tag, "_parity_err_cnt"}, pe_cnt, exp_pe);
  endtask

  // Pulse counters: each event must appear as exactly one high cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err)  fe_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  // Consumer/monitor: pops whenever a byte is presented and compares with the model queue.
  initial begin
    rd_mon = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_mon) begin
        rd_mon = 1'b0;
      end else if (consume_en && !rst && ifc.rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected: got byte %0h with none expected", ifc.rx_data);
        end else begin
          check("rd_data", {24'd0, ifc.rx_data}, {24'd0, exp_q.pop_front()});
        end
        rd_mon = 1'b1;
      end
    end
  end

  initial begin
    int         n;
    logic [7:0] head;
    logic [7:0] d;
    bit         s_ok;
    bit         p_ok;

    rst    = 1'b1;
    rx     = 1'b1;
    rd_tst = 1'b0;
    wait_cycles(3);
    check("rst_rx_ready", {31'd0, ifc.rx_ready}, 32'd0);
    check("rst_rx_data", {24'd0, ifc.rx_data}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_pulses", {29'd0, frame_err, overrun, parity_err}, 32'd0);
    rst = 1'b0;
    wait_cycles(3);

    // Single frame: latency to rx_ready, data, pop, then hold-when-empty.
    n = 0;
    fork
      send_frame(8'h5A, 1'b1, 1'b1, BIT);
      begin
        while (!ifc.rx_ready && n < 400) begin
          wait_cycles(1);
          n++;
        end
      end
    join
    check("latency_5a", n, STOP_AT + 1);
    check("data_5a", {24'd0, ifc.rx_data}, {24'd0, exp_q[0]});
    void'(exp_q.pop_front());
    rd_tst = 1'b1;
    wait_cycles(1);
    rd_tst = 1'b0;
    check("ready_after_pop", {31'd0, ifc.rx_ready}, 32'd0);
    check("hold_when_empty", {24'd0, ifc.rx_data}, 32'h5A);

    // Glitch shorter than half a bit, plus a pop while empty.
    consume_en = 1'b1;
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(2 * BIT);
    check("glitch_busy", {31'd0, rx_busy}, 32'd0);
    rd_tst = 1'b1;
    wait_cycles(1);
    rd_tst = 1'b0;
    wait_cycles(1);
    check("glitch_ready", {31'd0, ifc.rx_ready}, 32'd0);
    check_errs("glitch");

    // Bad stop bit, then a good frame.
    send_frame(8'hC3, 1'b0, 1'b1, 2 * BIT);
    send_frame(8'h11, 1'b1, 1'b1, BIT);
    wait_drain();
    check_errs("frame");

    // Five back-to-back frames with no reads: fifth overruns.
    consume_en = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1, 0);
    wait_cycles(BIT);
    check("full_ready", {31'd0, ifc.rx_ready}, 32'd1);
    check_errs("overrun");
    consume_en = 1'b1;
    wait_drain();

    // Full FIFO with a pop on the fifth stop-sample cycle: no overrun.
    consume_en = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1, 0);
    head = exp_q.pop_front();
    fork
      send_frame(8'h05, 1'b1, 1'b1, BIT);
      begin
        repeat (STOP_AT) @(posedge clk);
        #1;
        rd_tst = 1'b1;
        check("pop_same_cycle_data", {24'd0, ifc.rx_data}, {24'd0, head});
        wait_cycles(1);
        rd_tst = 1'b0;
      end
    join
    check_errs("full_pop");
    consume_en = 1'b1;
    wait_drain();

    // Reset in the middle of frame 0xFF, then a good frame.
    rx = 1'b0;
    wait_cycles(BIT);
    rx = 1'b1;
    wait_cycles(3 * BIT);
    check("mid_frame_busy", {31'd0, rx_busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_mid_ready", {31'd0, ifc.rx_ready}, 32'd0);
    check("rst_mid_data", {24'd0, ifc.rx_data}, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);
    send_frame(8'h3C, 1'b1, 1'b1, BIT);
    wait_drain();

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0, BIT);
      wait_drain();
      check_errs("parity");
    end

    // Randomized frames with occasional bad stop/parity bits.
    for (int i = 0; i < 10; i++) begin
      d    = 8'($urandom);
      s_ok = ($urandom_range(0, 3) != 0);
      p_ok = ($urandom_range(0, 3) != 0);
      send_frame(d, s_ok, p_ok, s_ok ? int'($urandom_range(0, BIT)) : 2 * BIT);
    end
    wait_drain();
    check_errs("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
